// File: rtl/config_loader.sv
// Serial configuration loader: hunts for a sync word, then loads NUM_SLICES
// parity-protected 32-bit LUT words and writes each one to its slice.
module config_loader #(
  parameter int          NUM_SLICES = 8,
  parameter logic [7:0]  SYNC_WORD  = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cfg_start,
  input  logic        cfg_din,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [3:0]  lut_addr,
  output logic [31:0] lut_data,
  output logic        lut_we,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // state   | meaning
  // IDLE    | waiting for cfg_start after reset
  // SYNC    | sliding search for SYNC_WORD
  // DATA    | shifting in 32 data bits of the current word
  // PAR     | checking the even-parity bit of the current word
  // WRITE   | one-cycle LUT write strobe
  // DONE    | all slices loaded, slices enabled
  // ERROR   | parity failure, slices disabled
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_DATA, S_PAR, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [3:0] LAST_SLICE = 4'(NUM_SLICES - 1);

  state_t      state, state_nxt;
  logic [7:0]  sync_sr;
  logic [31:0] data_sr;
  logic [4:0]  bit_cnt;
  logic [3:0]  slice_cnt;
  logic        take;
  logic        sync_hit;
  logic        par_ok;
  logic        last_slice;

  // A restart wins over any bit presented in the same cycle.
  assign take       = cfg_valid && cfg_ready && !cfg_start;
  assign sync_hit   = ({sync_sr[6:0], cfg_din} == SYNC_WORD);
  assign par_ok     = ~(^data_sr ^ cfg_din);
  assign last_slice = (slice_cnt == LAST_SLICE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cfg_start) begin
      state_nxt = S_SYNC;
    end else begin
      unique case (state)
        S_SYNC:  if (take && sync_hit) state_nxt = S_DATA;
        S_DATA:  if (take && bit_cnt == 5'd31) state_nxt = S_PAR;
        S_PAR:   if (take) state_nxt = par_ok ? S_WRITE : S_ERROR;
        S_WRITE: state_nxt = last_slice ? S_DONE : S_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    lut_we    = 1'b0;
    done      = 1'b0;
    en        = 1'b0;
    err       = 1'b0;
    unique case (state)
      S_SYNC, S_DATA, S_PAR: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      S_WRITE: begin
        busy   = 1'b1;
        lut_we = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        en   = 1'b1;
      end
      S_ERROR: err = 1'b1;
      default: ;
    endcase
  end

  // Write address/data are captured as the parity bit passes so they are
  // already valid during the WRITE cycle and then simply hold.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_sr   <= '0;
      data_sr   <= '0;
      bit_cnt   <= '0;
      slice_cnt <= '0;
      lut_addr  <= '0;
      lut_data  <= '0;
    end else if (cfg_start) begin
      sync_sr   <= '0;
      data_sr   <= '0;
      bit_cnt   <= '0;
      slice_cnt <= '0;
    end else begin
      unique case (state)
        S_SYNC: if (take) sync_sr <= {sync_sr[6:0], cfg_din};
        S_DATA: if (take) begin
          data_sr <= {data_sr[30:0], cfg_din};
          bit_cnt <= bit_cnt + 5'd1;
        end
        S_PAR: if (take && par_ok) begin
          lut_addr <= slice_cnt;
          lut_data <= data_sr;
        end
        S_WRITE: if (!last_slice) slice_cnt <= slice_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Randomized and directed bench for config_loader; expected LUT writes come
// from a bit-list model of the frame format.
module tb_config_loader;
  localparam int         NS = 2;
  localparam logic [7:0] SW = 8'hA5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_din = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  lut_addr;
  logic [31:0] lut_data;
  logic        lut_we, en, busy, done, err;

  config_loader #(.NUM_SLICES(NS), .SYNC_WORD(SW)) dut (
    .CLK(CLK), .RST(RST), .cfg_start(cfg_start), .cfg_din(cfg_din),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .lut_addr(lut_addr),
    .lut_data(lut_data), .lut_we(lut_we), .en(en), .busy(busy),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  logic [35:0] got_q[$];
  logic [35:0] exp_q[$];
  longint      wr_cyc[$];
  longint      xfer_cyc[$];
  bit          stim[$];
  bit          exp_done, exp_err;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (lut_we) begin
      got_q.push_back({lut_addr, lut_data});
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, req);
    end
  endtask

  // Reference: slide an 8-bit window for the sync word, then consume
  // 33-bit groups (32 data MSB first + even parity) per slice.
  function automatic void model(input bit bits[$]);
    logic [7:0]  win;
    logic [31:0] w;
    bit          p, found;
    int          i;
    win = '0; found = 1'b0; i = 0;
    exp_q.delete(); exp_done = 1'b0; exp_err = 1'b0;
    while (i < bits.size() && !found) begin
      win = {win[6:0], bits[i]};
      i++;
      if (win == SW) found = 1'b1;
    end
    if (!found) return;
    for (int s = 0; s < NS; s++) begin
      if (i + 33 > bits.size()) return;
      for (int k = 0; k < 32; k++) w[31-k] = bits[i+k];
      p = bits[i+32];
      i += 33;
      if ((($countones(w) + int'(p)) % 2) != 0) begin
        exp_err = 1'b1;
        return;
      end
      exp_q.push_back({4'(s), w});
    end
    exp_done = 1'b1;
  endfunction

  function automatic void push_bits(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) stim.push_back(v[k]);
  endfunction

  function automatic void push_word(input logic [31:0] w, input bit p);
    push_bits(w, 32);
    stim.push_back(p);
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ready"}, 64'(cfg_ready), 0);
    check_val({tag, "_addr"},  64'(lut_addr),  0);
    check_val({tag, "_data"},  64'(lut_data),  0);
    check_val({tag, "_we"},    64'(lut_we),    0);
    check_val({tag, "_en"},    64'(en),        0);
    check_val({tag, "_busy"},  64'(busy),      0);
    check_val({tag, "_done"},  64'(done),      0);
    check_val({tag, "_err"},   64'(err),       0);
  endtask

  task automatic start_pulse();
    @(negedge CLK);
    got_q.delete(); wr_cyc.delete(); xfer_cyc.delete();
    cfg_start = 1'b1; cfg_valid = 1'b0;
    @(negedge CLK);
    cfg_start = 1'b0;
  endtask

  task automatic drive_bit(input bit b, input bit gaps);
    int w;
    if (gaps) begin
      int n;
      n = int'($urandom_range(0, 3));
      repeat (n) begin
        @(negedge CLK);
        cfg_valid = 1'b0;
        cfg_din = 1'($urandom);
      end
    end
    @(negedge CLK);
    if (done || err) begin
      cfg_valid = 1'b0;
      return;
    end
    cfg_valid = 1'b1;
    cfg_din = b;
    w = 0;
    while (!cfg_ready && w < 60) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 60) check_val("ready_timeout", 64'(cfg_ready), 1);
    else xfer_cyc.push_back(cyc);
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stim[i]) drive_bit(stim[i], gaps);
    @(negedge CLK);
    cfg_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int n;
    repeat (4) @(negedge CLK);
    check_val({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_val({tag, "_wr"}, 64'(got_q[i]), 64'(exp_q[i]));
    check_val({tag, "_done"}, 64'(done), 64'(exp_done));
    check_val({tag, "_err"},  64'(err),  64'(exp_err));
    check_val({tag, "_en"},   64'(en),   64'(exp_done));
    check_val({tag, "_busy"}, 64'(busy), 64'(!exp_done && !exp_err));
  endtask

  task automatic basic_stim();
    stim.delete();
    push_bits(32'(SW), 8);
    push_word(32'h12345678, 1'b1);
    push_word(32'hFFFF0000, 1'b0);
  endtask

  initial begin
    logic [31:0] w;
    bit          p;
    int          nz;

    // Reset state
    repeat (3) @(negedge CLK);
    check_outputs_zero("rst");
    RST = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      cfg_valid = 1'($urandom);
      cfg_din = 1'($urandom);
    end
    @(negedge CLK);
    cfg_valid = 1'b0;
    check_val("idle_busy", 64'(busy), 0);
    check_val("idle_ready", 64'(cfg_ready), 0);
    check_val("idle_nwr", 64'(got_q.size()), 0);

    // Basic two-slice frame, plus write latency after the first parity bit
    basic_stim();
    model(stim);
    start_pulse();
    send_stream(1'b0);
    finish_frame("basic");
    if (wr_cyc.size() > 0 && xfer_cyc.size() > 40)
      check_val("wr_latency", 64'(wr_cyc[0] - xfer_cyc[40]), 1);
    else
      check_val("wr_latency_samples", 64'(wr_cyc.size()), 2);

    // Sync ending at the 9th preamble bit
    stim.delete();
    push_bits(32'h1A5, 9);
    push_word(32'h12345678, 1'b1);
    push_word(32'hFFFF0000, 1'b0);
    model(stim);
    start_pulse();
    send_stream(1'b0);
    finish_frame("preamble");

    // Parity failure on the first word, then recovery
    stim.delete();
    push_bits(32'(SW), 8);
    push_word(32'h00000001, 1'b0);
    push_word(32'hFFFF0000, 1'b0);
    model(stim);
    start_pulse();
    send_stream(1'b0);
    finish_frame("parerr");
    basic_stim();
    model(stim);
    start_pulse();
    send_stream(1'b0);
    finish_frame("recover");

    // Same frame with random valid gaps
    basic_stim();
    model(stim);
    start_pulse();
    send_stream(1'b1);
    finish_frame("gaps");

    // Random frames: noise preamble, random words, occasional bad parity
    for (int f = 0; f < 12; f++) begin
      stim.delete();
      nz = int'($urandom_range(0, 12));
      for (int k = 0; k < nz; k++) stim.push_back(1'($urandom));
      push_bits(32'(SW), 8);
      for (int s = 0; s < NS; s++) begin
        w = $urandom;
        p = ^w;
        if ($urandom_range(0, 7) == 0) p = ~p;
        push_word(w, p);
      end
      model(stim);
      start_pulse();
      send_stream(1'($urandom));
      finish_frame("rand");
    end

    // Reset after 20 data bits
    stim.delete();
    push_bits(32'(SW), 8);
    push_bits(32'hABCDE, 20);
    start_pulse();
    foreach (stim[i]) drive_bit(stim[i], 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    cfg_valid = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) begin
      @(negedge CLK);
      cfg_valid = 1'($urandom);
      cfg_din = 1'($urandom);
    end
    @(negedge CLK);
    cfg_valid = 1'b0;
    check_val("postrst_nwr", 64'(got_q.size()), 0);
    check_val("postrst_busy", 64'(busy), 0);
    basic_stim();
    model(stim);
    start_pulse();
    send_stream(1'b0);
    finish_frame("postrst");

    // cfg_start together with a valid bit while in DATA
    stim.delete();
    push_bits(32'(SW), 8);
    push_bits(32'h3FF, 10);
    start_pulse();
    foreach (stim[i]) drive_bit(stim[i], 1'b0);
    @(negedge CLK);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_din = 1'b1;
    @(negedge CLK);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    got_q.delete();
    check_val("restart_busy", 64'(busy), 1);
    check_val("restart_ready", 64'(cfg_ready), 1);
    stim.delete();
    push_bits(32'h25, 7);
    push_bits(32'(SW), 8);
    push_word(32'hCAFEF00D, ^32'hCAFEF00D);
    push_word(32'h0000FFFF, 1'b0);
    model(stim);
    send_stream(1'b0);
    finish_frame("restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
